fifo_rr_arbiter: RTL and testbench
==================================

// Module: fifo_rr_arbiter
// PURPOSE
//  Wormhole round-robin arbiter sharing one 16-bit output link among NUM_REQ
//  32-deep flit FIFOs (FIFO_32depth read side: empty, combinational data_out, read).
//  Locks the grant to one FIFO from head flit to tail flit, drives that FIFO's
//  read strobe, and flags malformed or over-length packets. Sits at a router output port.
// PARAMETERS
//  NUM_REQ      4   number of requesting FIFOs (2..8)
//  MAX_PKT_LEN  16  max flits per packet incl. head/tail (2..255); watchdog limit
// PORTS
//  clk           in   1          clock, all state on posedge
//  reset         in   1          asynchronous, active-low reset
//  fifo_empty    in   NUM_REQ    empty flag per FIFO
//  fifo_data     in   16*NUM_REQ FIFO data_out; FIFO i at [16*i+15:16*i]
//  fifo_read     out  NUM_REQ    read strobe per FIFO (one-hot or zero)
//  out_data      out  16         flit to link
//  out_valid     out  1          out_data valid
//  out_ready     in   1          link accepts flit this cycle
//  grant         out  NUM_REQ    one-hot current owner, 0 when idle
//  busy          out  1          state==LOCKED
//  protocol_err  out  1          sticky error; cleared only by reset
// BEHAVIOUR
//  Flit type = data[15:14]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
//  Reset (async, reset==0): state=IDLE, grant=0, rr_ptr=0, flit_cnt=0,
//   protocol_err=0; so fifo_read=0, out_valid=0, out_data=0 immediately.
//  FSM IDLE: req = ~fifo_empty. If req!=0, select first i at or after rr_ptr
//   (cyclic search, wraps NUM_REQ-1 -> 0); grant<=onehot(i), flit_cnt<=0,
//   ->LOCKED. No flit moves in IDLE: 1-cycle arbitration bubble per packet.
//  FSM LOCKED: out_valid = ~fifo_empty[g]; out_data = fifo_data[g] (0 if !out_valid).
//   xfer = out_valid & out_ready; fifo_read[g] = xfer (combinational, same cycle).
//   out_valid may drop mid-packet (FIFO ran empty): hold lock, no xfer, no timeout.
//  On xfer: flit_cnt<=flit_cnt+1 (width $clog2(MAX_PKT_LEN+1), never wraps).
//   First flit (flit_cnt==0) must be HEAD or SINGLE, else protocol_err<=1; still forwarded.
//   Later flit of type HEAD or SINGLE -> protocol_err<=1; forwarded.
//   Release if flit is TAIL, or SINGLE as first flit, or flit_cnt+1==MAX_PKT_LEN
//   (last case also sets protocol_err). Release: ->IDLE, grant<=0,
//   rr_ptr<=(g==NUM_REQ-1)?0:g+1.
//  Latency: FIFO non-empty in IDLE -> out_valid next cycle; back-to-back flits
//   at 1/cycle while locked and out_ready=1.
//  Fairness: after owner i releases, every other pending FIFO is served before i again.
//  Requests from non-granted FIFOs never affect a locked packet.
//  Reset mid-packet: grant dropped instantly, no fifo_read; partial packet stays
//   in FIFO (upstream responsibility).
//  out_ready low: out_data/out_valid stable unless FIFO content changes; never read.
// TESTING
//  1 Reset low during LOCKED with out_ready=1 -> fifo_read, out_valid, grant, busy =0 same cycle.
//  2 FIFO1 holds HEAD,BODY,TAIL (0x8001,0x0002,0x4003), out_ready=1 -> IDLE 1 cyc,
//    then 3 flits on consecutive cycles, fifo_read[1]=1 x3, busy low after TAIL.
//  3 All 4 FIFOs hold one SINGLE (0xC00i), rr_ptr=0 -> served order 0,1,2,3,
//    each 2 cycles; refill FIFO0 after grant -> served only after 3.
//  4 FIFO2 HEAD,BODY, then empty 3 cycles, then TAIL while FIFO0 requests ->
//    lock held on 2, out_valid=0 during gap, FIFO0 granted only after TAIL.
//  5 out_ready=0 for 5 cycles on HEAD 0x8AAA -> out_data=0x8AAA held, fifo_read=0.
//  6 MAX_PKT_LEN=4, FIFO3 HEAD+5 BODY -> 4 flits out, forced release, protocol_err=1;
//    BODY-first packet also sets protocol_err.

Source files
------------

// File: rtl/fifo_rr_arbiter_if.sv
// Bundle of FIFO read-side and output-link signals for the wormhole round-robin arbiter.
// slave = arbiter side, master = FIFOs plus downstream link.
interface fifo_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    fifo_empty;
  logic [16*NUM_REQ-1:0] fifo_data;
  logic [NUM_REQ-1:0]    fifo_read;
  logic [15:0]           out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic                  protocol_err;

  modport slave (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read, out_data, out_valid, grant, busy, protocol_err
  );

  modport master (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read, out_data, out_valid, grant, busy, protocol_err
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Wormhole round-robin arbiter: locks one FIFO onto the 16-bit output link from head
// to tail flit, strobes its read combinationally, and flags malformed/over-length packets.
//
// state  | meaning
// IDLE   | no owner; pick next non-empty FIFO at/after rr_ptr (one-cycle bubble)
// LOCKED | grant held by one FIFO until tail, first-flit single, or length limit
module fifo_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 16
) (
  input logic               clk,
  input logic               reset,
  fifo_rr_arbiter_if.slave  bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MAX_PKT_LEN + 1);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]    gidx_q, gidx_d;
  logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]    flit_cnt_q, flit_cnt_d;
  logic               err_q, err_d;

  logic        sel_found;
  int          sel_idx;
  int          probe;
  logic [15:0] head_flit;
  logic [1:0]  ftype;
  logic        vld;
  logic        xfer;
  logic        first_flit;
  logic        at_max;
  logic        rel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      flit_cnt_q <= flit_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
    err_d      = err_q;

    // Cyclic search starting at rr_ptr; first non-empty FIFO wins.
    sel_found = 1'b0;
    sel_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = int'(rr_ptr_q) + k;
      if (probe >= NUM_REQ) probe = probe - NUM_REQ;
      if (!sel_found && !bus.fifo_empty[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end

    head_flit  = bus.fifo_data[{gidx_q, 4'b0000} +: 16];
    ftype      = head_flit[15:14];
    vld        = (state_q == LOCKED) && !bus.fifo_empty[gidx_q];
    xfer       = vld && bus.out_ready;
    first_flit = (flit_cnt_q == '0);
    at_max     = (int'(flit_cnt_q) + 1 == MAX_PKT_LEN);
    rel        = 1'b0;

    bus.out_valid    = vld;
    bus.out_data     = vld ? head_flit : 16'h0000;
    bus.fifo_read    = xfer ? grant_q : '0;
    bus.grant        = grant_q;
    bus.busy         = (state_q == LOCKED);
    bus.protocol_err = err_q;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (i == sel_idx);
          gidx_d     = IDXW'(sel_idx);
          flit_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (first_flit && !(ftype == FT_HEAD || ftype == FT_SINGLE)) err_d = 1'b1;
          if (!first_flit && (ftype == FT_HEAD || ftype == FT_SINGLE)) err_d = 1'b1;
          if (ftype == FT_TAIL || (first_flit && ftype == FT_SINGLE)) begin
            rel = 1'b1;
          end else if (at_max) begin
            // Length limit hit without a terminating flit: cut the packet off.
            rel   = 1'b1;
            err_d = 1'b1;
          end
          if (rel) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic unused_body;
  assign unused_body = (FT_BODY == 2'b00);
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: modelled flit FIFOs, per-source scoreboard,
// a packet vector table, and hand sequences for reset, ordering, gaps and backpressure.
module tb_fifo_rr_arbiter;
  localparam int NR   = 4;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NUM_REQ(NR)) bus ();
  fifo_rr_arbiter #(.NUM_REQ(NR), .MAX_PKT_LEN(MAXL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int               src;
    int               len;
    logic [5:0][15:0] f;
    int               nout;
    logic             err;
  } vec_t;

  typedef struct {
    logic        busy;
    logic        ov;
    logic [3:0]  rd;
    logic [3:0]  gr;
    logic [15:0] d;
  } cyc_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] fq[NR][$];
  logic [15:0] sb[NR][$];
  int served_q[$];
  int served_cyc[$];
  int cyc   = 0;
  int xfers = 0;
  vec_t tv[8];
  cyc_t ct[5];
  logic refilled;
  logic done;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic int oh2i(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic vec_t mk(int src, int len, int nout, logic err,
                              logic [15:0] w0, logic [15:0] w1, logic [15:0] w2,
                              logic [15:0] w3, logic [15:0] w4, logic [15:0] w5);
    vec_t v;
    v.src = src; v.len = len; v.nout = nout; v.err = err;
    v.f[0] = w0; v.f[1] = w1; v.f[2] = w2; v.f[3] = w3; v.f[4] = w4; v.f[5] = w5;
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.fifo_empty[i] = (fq[i].size() == 0);
      bus.fifo_data[16*i +: 16] = (fq[i].size() != 0) ? fq[i][0] : 16'h0000;
    end
  endtask

  task automatic push(int i, logic [15:0] d);
    fq[i].push_back(d);
    sb[i].push_back(d);
    drive();
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick();
    logic [NR-1:0] rd;
    int g;
    #1;
    rd = bus.fifo_read;
    if (bus.out_valid && bus.out_ready) begin
      g = oh2i(bus.grant);
      xfers++;
      served_q.push_back(g);
      served_cyc.push_back(cyc);
      chk("read_eq_grant", rd, bus.grant);
      if (g < 0) fail("xfer_no_owner");
      else if (sb[g].size() == 0) fail("xfer_unexpected");
      else chk("xfer_data", bus.out_data, sb[g].pop_front());
    end else begin
      chk("no_read_idle", rd, 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      fq[i].delete();
      sb[i].delete();
    end
    served_q.delete();
    served_cyc.delete();
    xfers = 0;
    bus.out_ready = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = mk(1, 3, 3, 1'b0, 16'h8001, 16'h0002, 16'h4003, 16'h0, 16'h0, 16'h0);
    tv[1] = mk(3, 1, 1, 1'b0, 16'hC005, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[2] = mk(3, 6, 4, 1'b1, 16'h8301, 16'h0302, 16'h0303, 16'h0304, 16'h0305, 16'h0306);
    tv[3] = mk(0, 2, 2, 1'b1, 16'h0001, 16'h4002, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[4] = mk(2, 3, 3, 1'b1, 16'h8201, 16'h8202, 16'h4203, 16'h0, 16'h0, 16'h0);
    tv[5] = mk(0, 2, 2, 1'b0, 16'h8001, 16'h4002, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[6] = mk(1, 1, 1, 1'b1, 16'h4011, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[7] = mk(2, 3, 3, 1'b1, 16'h8001, 16'hC002, 16'h4003, 16'h0, 16'h0, 16'h0);

    ct[0] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    ct[1] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 16'h8001};
    ct[2] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 16'h0002};
    ct[3] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 16'h4003};
    ct[4] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};

    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.fifo_empty = '1;
    bus.fifo_data = '0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_read", bus.fifo_read, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_err", bus.protocol_err, 0);
    @(negedge clk);

    // Packet vector table
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int k = 0; k < tv[t].len; k++) push(tv[t].src, tv[t].f[k]);
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
        tick();
        #1;
        if (xfers == tv[t].nout && !bus.busy) done = 1'b1;
      end
      if (!done) fail("pkt_timeout");
      chk("pkt_flits", xfers, tv[t].nout);
      chk("pkt_err", bus.protocol_err, tv[t].err);
      chk("pkt_fifo_left", fq[tv[t].src].size(), tv[t].len - tv[t].nout);
      @(negedge clk);
    end

    // Cycle-accurate head/body/tail from FIFO1
    do_reset();
    push(1, 16'h8001); push(1, 16'h0002); push(1, 16'h4003);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("seq_busy", bus.busy, ct[c].busy);
      chk("seq_valid", bus.out_valid, ct[c].ov);
      chk("seq_read", bus.fifo_read, ct[c].rd);
      chk("seq_grant", bus.grant, ct[c].gr);
      chk("seq_data", bus.out_data, ct[c].d);
      tick();
    end

    // Reset asserted mid-packet
    do_reset();
    push(1, 16'h8001); push(1, 16'h0002); push(1, 16'h4003);
    tick();
    #1;
    chk("midrst_pre_read", bus.fifo_read, 4'b0010);
    reset = 1'b0;
    #1;
    chk("midrst_read", bus.fifo_read, 0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    chk("midrst_fifo_kept", fq[1].size(), 3);
    @(negedge clk);

    // Round-robin order with refill of FIFO0 after it is served
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 16'hC000 | 16'(i));
    refilled = 1'b0;
    for (int n = 0; n < 40 && served_q.size() < 5; n++) begin
      tick();
      if (!refilled && served_q.size() >= 1) begin
        push(0, 16'hC010);
        refilled = 1'b1;
      end
    end
    if (served_q.size() != 5) fail("rr_timeout");
    else begin
      chk("rr_order0", served_q[0], 0);
      chk("rr_order1", served_q[1], 1);
      chk("rr_order2", served_q[2], 2);
      chk("rr_order3", served_q[3], 3);
      chk("rr_order4", served_q[4], 0);
      for (int k = 1; k < 5; k++) chk("rr_spacing", served_cyc[k] - served_cyc[k-1], 2);
    end

    // FIFO2 runs dry mid-packet while FIFO0 waits
    do_reset();
    push(2, 16'h8201); push(2, 16'h0202);
    for (int n = 0; n < 10 && xfers < 2; n++) tick();
    if (xfers != 2) fail("gap_timeout");
    push(0, 16'hC0AA);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("gap_busy", bus.busy, 1);
      chk("gap_grant", bus.grant, 4'b0100);
      chk("gap_valid", bus.out_valid, 0);
      chk("gap_read", bus.fifo_read, 0);
      tick();
    end
    push(2, 16'h4203);
    tick();
    #1;
    chk("gap_after_tail_grant", bus.grant, 0);
    tick();
    #1;
    chk("gap_next_grant", bus.grant, 4'b0001);
    tick();
    chk("gap_sb0_empty", sb[0].size(), 0);
    chk("gap_sb2_empty", sb[2].size(), 0);
    chk("gap_err", bus.protocol_err, 0);

    // Backpressure on a head flit
    do_reset();
    bus.out_ready = 1'b0;
    push(0, 16'h8AAA);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_data", bus.out_data, 16'h8AAA);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_read", bus.fifo_read, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_delivered", xfers, 1);
    chk("bp_fifo_empty", fq[0].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
